hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage RV-lite core; sits beside the forwarding unit in the decode/execute area.
- Resolves hazards that forwarding cannot cover: load-use bubbles, taken-branch flushes, fetch stalls, data-memory wait freezes.
- Discards wrong-path fetch words.
- Drives per-stage enable/flush of PC, IF/ID, ID/EX, EX/MEM, MEM/WB. Flush dominates enable: a flushed register loads a NOP.

Parameters:
REG_W, 5, register index width
MEM_TIMEOUT, 64, consecutive dmem wait cycles before err_timeout (>=1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_rs1  in  REG_W  source 1 of instruction in ID
id_rs2  in  REG_W  source 2 of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
id_ex_rd  in  REG_W  destination of instruction in EX
id_ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump in EX redirects PC
imem_ready  in  1  fetch word valid this cycle
dmem_req  in  1  MEM stage has an access outstanding
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
id_ex_en  out  1  ID/EX load enable
ex_mem_en  out  1  EX/MEM load enable
mem_wb_en  out  1  MEM/WB load enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_flush  out  1  ID/EX loads NOP
err_timeout  out  1  sticky dmem timeout flag

Behaviour:
- Definitions: dmem_busy = dmem_req & !dmem_ready. load_use = id_ex_mem_read & id_ex_rd!=0 & ((id_rs1_used & id_rs1==id_ex_rd) | (id_rs2_used & id_rs2==id_ex_rd)).
- FSM states: INIT, RUN, DISCARD. Outputs are combinational from state and inputs, zero latency.
- Reset: state=INIT, timeout counter=0, err_timeout=0.
- INIT: all enables 0, both flushes 1. After one cycle -> RUN.
- RUN, evaluated in strict priority order:
  1. dmem_busy: all enables 0, flushes 0 (full freeze; EX is held, so a pending branch stays asserted).
  2. ex_branch_taken: pc_en=1 (loads target); if_id_flush=1; id_ex_flush=1; other enables 1. If !imem_ready the in-flight fetch is wrong-path -> DISCARD.
  3. load_use: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Exactly one bubble, because the next EX holds a NOP.
  4. !imem_ready: pc_en=0, if_id_en=1 with if_id_flush=1 (bubble); downstream enables 1.
  5. Otherwise: all enables 1, flushes 0.
- DISCARD: pc_en=0, if_id_flush=1, id_ex/ex_mem/mem_wb enables 1. The cycle imem_ready=1 the returned word is dropped -> RUN. dmem_busy still forces all enables 0, but an imem_ready in the same cycle still ends DISCARD.
- Timeout counter:
  - Increments on each dmem_busy cycle, clears on any non-busy cycle, saturates at MEM_TIMEOUT.
  - err_timeout sets when the count reaches MEM_TIMEOUT and holds until rst_n. It has no effect on sequencing.
- Reset assertion mid-stall or mid-DISCARD returns immediately to INIT.

Optional Feature:
- HAZ_PERF_CNT_EN defined: adds outputs perf_stall_cycles[31:0] (cycles with pc_en=0 outside INIT) and perf_flush_events[31:0] (taken-branch flushes).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: no ports, no counter logic.

Decomposition:
- hazard_pkg: state enum (INIT, RUN, DISCARD), REG_ZERO constant, timeout counter width function (clog2(MEM_TIMEOUT+1)).
- Sub-module hazard_lu_detect: combinational load_use compare, reused by future dual-issue work.

Test Plan:
- Reset release: first cycle all enables 0 and both flushes 1; second cycle with imem_ready=1, all enables 1.
- lw x5 in EX, ID reads x5 (rs1_used=1) -> one cycle pc_en=0, if_id_en=0, id_ex_flush=1. Same with id_ex_rd=0 -> no bubble.
- Taken branch with imem_ready=0 -> pc_en=1 and both flushes that cycle. Then 3 cycles DISCARD; the returned word is flushed; RUN resumes.
- dmem_req=1, dmem_ready=0 for 5 cycles while load-use and branch are both pending -> all enables 0. The branch flush appears in the cycle dmem_ready=1.
- MEM_TIMEOUT=4, dmem busy 4 cycles -> err_timeout rises in cycle 4 and stays high after dmem_ready; clears only on rst_n.
- Reset asserted while in DISCARD -> INIT outputs asynchronously, err_timeout=0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencing controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam int REG_ZERO = 0;

  function automatic int cnt_width(input int mem_timeout);
    return $clog2(mem_timeout + 1);
  endfunction

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use detector: a load in EX whose destination feeds the instruction in ID.
module hazard_lu_detect
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  output logic             load_use
);

  logic rd_live;
  logic hit1;
  logic hit2;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign rd_live  = ex_mem_read && (ex_rd != REG_W'(REG_ZERO));
  assign hit1     = rs1_used && (rs1 == ex_rd);
  assign hit2     = rs2_used && (rs2 == ex_rd);
  assign load_use = rd_live && (hit1 || hit2);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: per-stage enable/flush from load-use, branch, fetch and dmem-wait hazards.
// Optional HAZ_PERF_CNT_EN adds stall-cycle and branch-flush performance counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             err_timeout
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_stall_cycles,
  output logic [31:0]      perf_flush_events
`endif
);

  localparam int CNT_W = cnt_width(MEM_TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;
  logic             dmem_busy;
  logic             load_use;
  logic             hit_limit;

  assign dmem_busy = dmem_req && !dmem_ready;

  hazard_lu_detect #(
    .REG_W (REG_W)
  ) u_lu_detect (
    .rs1         (id_rs1),
    .rs2         (id_rs2),
    .rs1_used    (id_rs1_used),
    .rs2_used    (id_rs2_used),
    .ex_rd       (id_ex_rd),
    .ex_mem_read (id_ex_mem_read),
    .load_use    (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    case (state_q)
      ST_INIT: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        if (dmem_busy) begin
          // Full freeze: EX is held, so a pending branch is re-evaluated later.
        end else if (ex_branch_taken) begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (!imem_ready) begin
            state_d = ST_DISCARD;
          end
        end else if (load_use) begin
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          if_id_flush = 1'b1;
        end else begin
          pc_en       = 1'b1;
          if_id_en    = 1'b1;
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
        end
      end
      ST_DISCARD: begin
        if (!dmem_busy) begin
          id_ex_en    = 1'b1;
          ex_mem_en   = 1'b1;
          mem_wb_en   = 1'b1;
          if_id_flush = 1'b1;
        end
        // The wrong-path word arrives now and is never loaded into IF/ID.
        if (imem_ready) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // The flag is visible in the busy cycle that brings the count to the limit.
  assign hit_limit   = dmem_busy && (cnt_q >= CNT_W'(MEM_TIMEOUT - 1));
  assign err_timeout = err_q || hit_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (!dmem_busy) begin
        cnt_q <= '0;
      end else if (cnt_q != CNT_W'(MEM_TIMEOUT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (hit_limit) begin
        err_q <= 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_flush_events <= '0;
    end else begin
      if ((state_q != ST_INIT) && !pc_en) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if ((state_q == ST_RUN) && !dmem_busy && ex_branch_taken) begin
        perf_flush_events <= perf_flush_events + 32'd1;
      end
    end
  end
`endif

endmodule
